// File: rtl/memory_access.sv
// Memory stage: one data-memory load/store per instruction over a valid/ready bus,
// load alignment/extension, and the writeback register. Option: MEMORY_MISALIGN_TRAP_EN.
module memory_access (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_in,
   input  logic [31:0] next_pc_in,
   input  logic [31:0] alu_data_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] csr_data_in,
   input  logic        load_in,
   input  logic        store_in,
   input  logic [1:0]  load_store_size_in,
   input  logic        load_signed_in,
   input  logic [1:0]  write_select_in,
   input  logic [4:0]  rd_addr_in,
   input  logic [11:0] csr_addr_in,
   input  logic        mret_in,
   input  logic        wfi_in,
   input  logic        valid_in,
   input  logic        exception_in,
   input  logic [3:0]  ecause_in,
   input  logic        stall,
   input  logic        invalidate,
   output logic        mem_busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] next_pc_out,
   output logic [31:0] alu_data_out,
   output logic [31:0] csr_data_out,
   output logic [31:0] load_data_out,
   output logic [1:0]  write_select_out,
   output logic [4:0]  rd_addr_out,
   output logic [11:0] csr_addr_out,
   output logic        mret_out,
   output logic        wfi_out,
   output logic        valid_out,
   output logic        exception_out,
   output logic [3:0]  ecause_out
);

   typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

   function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
      logic [31:0] sh;
      logic        fill;
      sh = rdata >> {off, 3'b000};
      case (size)
         2'd0: begin
            fill = sgn & sh[7];
            return {{24{fill}}, sh[7:0]};
         end
         2'd1: begin
            fill = sgn & sh[15];
            return {{16{fill}}, sh[15:0]};
         end
         default: return sh;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        held_q, held_d;
   logic [31:0] held_data_q, held_data_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_wstrb_q, bus_wstrb_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;

   logic [31:0] pc_q, pc_d, next_pc_q, next_pc_d, alu_data_q, alu_data_d;
   logic [31:0] csr_data_q, csr_data_d, load_data_q, load_data_d;
   logic [1:0]  write_select_q, write_select_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [11:0] csr_addr_q, csr_addr_d;
   logic        mret_q, mret_d, wfi_q, wfi_d, valid_q, valid_d, exception_q, exception_d;
   logic [3:0]  ecause_q, ecause_d;

   logic [1:0]  off;
   logic        misaligned, go, xfer_done, upd, capture;
   logic        exc_c;
   logic [3:0]  cause_c;
   logic [3:0]  wstrb_c;
   logic [31:0] wdata_c, rdata_aligned, load_result;

   assign off = alu_data_in[1:0];

`ifdef MEMORY_MISALIGN_TRAP_EN
   assign misaligned = (load_in || store_in) &&
                       (((load_store_size_in == 2'd1) && off[0]) ||
                        (load_store_size_in[1] && (off != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   // held_q blocks a reissue after a transfer finished under stall
   assign go = valid_in && !exception_in && !invalidate && (load_in || store_in)
               && !misaligned && !held_q;

   always_comb begin
      case (load_store_size_in)
         2'd0: begin
            wstrb_c = 4'b0001 << off;
            wdata_c = {4{rs2_data_in[7:0]}};
         end
         2'd1: begin
            wstrb_c = 4'b0011 << off;
            wdata_c = {2{rs2_data_in[15:0]}};
         end
         default: begin
            wstrb_c = 4'b1111;
            wdata_c = rs2_data_in;
         end
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = bus_we_q;
      mem_addr  = bus_addr_q;
      mem_wstrb = bus_wstrb_q;
      mem_wdata = bus_wdata_q;
      case (state_q)
         IDLE: begin
            mem_req   = go;
            mem_we    = store_in;
            mem_addr  = {alu_data_in[31:2], 2'b00};
            mem_wstrb = wstrb_c;
            mem_wdata = wdata_c;
         end
         WAIT, KILL: mem_req = 1'b1;
         default: mem_req = 1'b0;
      endcase
   end

   assign mem_busy      = mem_req && !mem_ready;
   assign xfer_done     = mem_req && mem_ready;
   assign upd           = !stall && !mem_busy;
   assign capture       = upd && valid_in && !invalidate && (state_q != KILL);
   assign rdata_aligned = align_load(mem_rdata, off, load_store_size_in, load_signed_in);

   always_comb begin
      load_result = 32'd0;
      if (load_in) begin
         if (held_q)         load_result = held_data_q;
         else if (xfer_done) load_result = rdata_aligned;
      end
   end

   always_comb begin
      exc_c   = exception_in;
      cause_c = ecause_in;
`ifdef MEMORY_MISALIGN_TRAP_EN
      if (!exception_in && misaligned) begin
         exc_c   = 1'b1;
         cause_c = load_in ? 4'd4 : 4'd6;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      held_d      = held_q;
      held_data_d = held_data_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_wdata_d = bus_wdata_q;
      case (state_q)
         IDLE: if (go && !mem_ready) state_d = WAIT;
         WAIT: begin
            if (mem_ready)       state_d = IDLE;
            else if (invalidate) state_d = KILL;
         end
         KILL: if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q == IDLE && go) begin
         bus_we_d    = store_in;
         bus_addr_d  = {alu_data_in[31:2], 2'b00};
         bus_wstrb_d = wstrb_c;
         bus_wdata_d = wdata_c;
      end
      if (upd) begin
         held_d = 1'b0;
      end else if (xfer_done && state_q != KILL && !invalidate) begin
         held_d      = 1'b1;
         held_data_d = rdata_aligned;
      end
   end

   always_comb begin
      pc_d           = pc_q;
      next_pc_d      = next_pc_q;
      alu_data_d     = alu_data_q;
      csr_data_d     = csr_data_q;
      load_data_d    = load_data_q;
      write_select_d = write_select_q;
      rd_addr_d      = rd_addr_q;
      csr_addr_d     = csr_addr_q;
      mret_d         = mret_q;
      wfi_d          = wfi_q;
      valid_d        = valid_q;
      exception_d    = exception_q;
      ecause_d       = ecause_q;
      if (upd) begin
         valid_d = capture;
         if (capture) begin
            pc_d           = pc_in;
            next_pc_d      = next_pc_in;
            alu_data_d     = alu_data_in;
            csr_data_d     = csr_data_in;
            load_data_d    = load_result;
            write_select_d = write_select_in;
            rd_addr_d      = rd_addr_in;
            csr_addr_d     = csr_addr_in;
            mret_d         = mret_in;
            wfi_d          = wfi_in;
            exception_d    = exc_c;
            ecause_d       = cause_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         held_q         <= 1'b0;
         held_data_q    <= '0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_wstrb_q    <= '0;
         bus_wdata_q    <= '0;
         pc_q           <= '0;
         next_pc_q      <= '0;
         alu_data_q     <= '0;
         csr_data_q     <= '0;
         load_data_q    <= '0;
         write_select_q <= '0;
         rd_addr_q      <= '0;
         csr_addr_q     <= '0;
         mret_q         <= 1'b0;
         wfi_q          <= 1'b0;
         valid_q        <= 1'b0;
         exception_q    <= 1'b0;
         ecause_q       <= '0;
      end else begin
         state_q        <= state_d;
         held_q         <= held_d;
         held_data_q    <= held_data_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_wstrb_q    <= bus_wstrb_d;
         bus_wdata_q    <= bus_wdata_d;
         pc_q           <= pc_d;
         next_pc_q      <= next_pc_d;
         alu_data_q     <= alu_data_d;
         csr_data_q     <= csr_data_d;
         load_data_q    <= load_data_d;
         write_select_q <= write_select_d;
         rd_addr_q      <= rd_addr_d;
         csr_addr_q     <= csr_addr_d;
         mret_q         <= mret_d;
         wfi_q          <= wfi_d;
         valid_q        <= valid_d;
         exception_q    <= exception_d;
         ecause_q       <= ecause_d;
      end
   end

   assign pc_out           = pc_q;
   assign next_pc_out      = next_pc_q;
   assign alu_data_out     = alu_data_q;
   assign csr_data_out     = csr_data_q;
   assign load_data_out    = load_data_q;
   assign write_select_out = write_select_q;
   assign rd_addr_out      = rd_addr_q;
   assign csr_addr_out     = csr_addr_q;
   assign mret_out         = mret_q;
   assign wfi_out          = wfi_q;
   assign valid_out        = valid_q;
   assign exception_out    = exception_q;
   assign ecause_out       = ecause_q;

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage pipeline, between execute and writeback. Takes the registered execute results, performs at most one data-memory load or store per instruction over a valid/ready bus, and aligns and sign-extends load data. Raises misaligned-access exceptions and stalls the pipeline while a bus transfer is outstanding. Registers everything writeback needs.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- reset_n  in  1  synchronous, active-low reset
- pc_in, next_pc_in  in  32  instruction PC and sequential PC from execute
- alu_data_in  in  32  ALU result; the effective address for loads and stores
- rs2_data_in  in  32  store data
- csr_data_in  in  32  CSR read value, passed through
- load_in, store_in  in  1  access type
- load_store_size_in  in  2  0 = byte, 1 = half, 2 = word
- load_signed_in  in  1  sign-extend load result
- write_select_in  in  2  writeback source select, passed through
- rd_addr_in  in  5  destination register, passed through
- csr_addr_in  in  12  destination CSR, passed through
- mret_in, wfi_in  in  1  passed through
- valid_in, exception_in  in  1  slot valid; exception already pending
- ecause_in  in  4  pending exception cause
- stall, invalidate  in  1  from hazard unit
- mem_busy  out  1  to hazard unit: access outstanding this cycle
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  {alu_data_in[31:2], 2'b00}
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid in the cycle mem_ready is high
- mem_ready  in  1  transfer completes when mem_req && mem_ready
- pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out  out  32  registered, to writeback
- write_select_out  out  2, rd_addr_out  out  5, csr_addr_out  out  12, mret_out, wfi_out  out  1  registered
- valid_out, exception_out  out  1; ecause_out  out  4  registered

## Operation
- Access condition `go` = valid_in && !exception_in && !invalidate && (load_in || store_in) && !misaligned.
- Misaligned means a half access with addr[0] = 1, or a word access with addr[1:0] != 0.
- FSM states:
  - IDLE: mem_req = go.
    - If go && !mem_ready, move to WAIT.
  - WAIT: mem_req = 1; all bus outputs are held, because the inputs are frozen by the stall.
    - mem_ready moves the FSM to IDLE.
    - invalidate while in WAIT moves the FSM to KILL.
  - KILL: mem_req = 1. The transfer already issued must complete, and its result is discarded.
    - mem_ready moves the FSM to IDLE, with a bubble written.
- mem_busy = mem_req && !mem_ready.
- Write strobes by size, with off = addr[1:0]:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- Write data: byte is {4{rs2[7:0]}}, half is {2{rs2[15:0]}}, word is rs2.
- Load data: shift mem_rdata right by 8*off, then truncate to the access size. Fill the upper bits with the sign bit if load_signed_in, else with zeros.
- Output register update happens when !stall && !mem_busy:
  - If valid_in && !invalidate and the state is not KILL, capture all pass-through fields, load_data_out, and valid_out = 1.
  - Otherwise valid_out = 0 (bubble) and the other outputs hold.
- Exception priority:
  - exception_in: passed through unchanged, and no access is made.
  - Misaligned load: ecause_out = 4, exception_out = 1.
  - Misaligned store: ecause_out = 6, exception_out = 1.
- Exceptions and non-memory instructions never assert mem_req.

## Timing
- Reset (reset_n low at a clk edge):
  - FSM goes to IDLE and mem_req falls the next cycle.
  - valid_out, exception_out, mret_out and wfi_out are 0.
  - All other registered outputs are 0.
- Reset in the middle of a transfer abandons it without waiting for mem_ready. The bus slave must tolerate this.
- Zero-wait access (ready in the request cycle): result registered at the next edge, latency 1. No stall.
- N wait cycles: mem_busy is high for N cycles; the result is registered at the edge where mem_ready is sampled.
- External stall with mem_ready arriving in the same cycle: the bus transfer completes, but the output register does not capture. Hold the captured load_data in an internal latch and present it when the stall drops. The request must not reissue.
- Invalidate together with mem_ready in WAIT: the transfer completes and valid_out = 0.

## Configuration
- `MEMORY_MISALIGN_TRAP_EN`
  - Defined: misaligned accesses raise cause 4 or 6 as above.
  - Undefined: misalignment is not checked. The access uses the word-aligned address, wstrb is masked to bits inside the word, and no exception is raised.

## Test plan
- Byte store of rs2 = 0x12345678 at addr 0x103, ready the same cycle -> mem_wstrb = 4'b1000, mem_wdata = 0x78787878, mem_busy never high.
- Signed half load at 0x202 with mem_rdata = 0x8001_0000 and 2 wait cycles -> mem_busy high for 2 cycles, load_data_out = 0xFFFF8001, valid_out = 1.
- Word load at 0x101 with the macro defined -> no mem_req, exception_out = 1, ecause_out = 4. With the macro undefined -> mem_req asserted with addr 0x100.
- Invalidate asserted during WAIT, ready 3 cycles later -> mem_req held until ready, then valid_out = 0 and no register write.
- reset_n low during WAIT -> mem_req = 0 and valid_out = 0 the next cycle, FSM in IDLE.
